ttt_move_ctrl: RTL and testbench

Move controller for the tic-tac-toe board. Arbitrates move requests from two players, enforces turn order and cell legality, and drives the board's set/row/col/reset inputs one move at a time. Tracks the board's game_state after each move, forfeits a player whose turn times out, and latches the final result. Sits between the player input logic and the board instance.

---
 rtl/ttt_move_ctrl_if.sv | 43 ++++
 rtl/ttt_move_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ttt_move_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ttt_move_ctrl_if.sv
// Player and board signal bundle for the tic-tac-toe move controller.
// master = controller side, slave = players plus board side.
interface ttt_move_ctrl_if;
   logic       new_game;
   logic       p0_req;
   logic       p1_req;
   logic [1:0] p0_row;
   logic [1:0] p0_col;
   logic [1:0] p1_row;
   logic [1:0] p1_col;
   logic       p0_ack;
   logic       p0_nack;
   logic       p1_ack;
   logic       p1_nack;
   logic [8:0] board_valid;
   logic [1:0] board_game_state;
   logic       board_set;
   logic       board_reset;
   logic [1:0] board_row;
   logic [1:0] board_col;
   logic       turn;
   logic       busy;
   logic [1:0] result;
   logic       forfeit;

   modport master (
      input  new_game, p0_req, p1_req,
      input  p0_row, p0_col, p1_row, p1_col,
      input  board_valid, board_game_state,
      output p0_ack, p0_nack, p1_ack, p1_nack,
      output board_set, board_reset, board_row, board_col,
      output turn, busy, result, forfeit
   );

   modport slave (
      output new_game, p0_req, p1_req,
      output p0_row, p0_col, p1_row, p1_col,
      output board_valid, board_game_state,
      input  p0_ack, p0_nack, p1_ack, p1_nack,
      input  board_set, board_reset, board_row, board_col,
      input  turn, busy, result, forfeit
   );
endinterface

// File: rtl/ttt_move_ctrl.sv
// Tic-tac-toe move controller: turn arbitration, legality check,
// one board write per move, turn timeout and result latching.
module ttt_move_ctrl #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNT_W          = 10
) (
   input logic             clk,
   input logic             reset,
   ttt_move_ctrl_if.master io
);

   localparam logic [2:0] S_CLEAR  = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_ISSUE  = 3'd2;
   localparam logic [2:0] S_SETTLE = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [2:0]       state_q, state_d;
   logic             turn_q, turn_d;
   logic [1:0]       result_q, result_d;
   logic             forfeit_q, forfeit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             set_q, set_d;
   logic             clr_q, clr_d;
   logic             busy_q, busy_d;
   logic [1:0]       row_q, row_d;
   logic [1:0]       col_q, col_d;
   logic [1:0]       ack_q, ack_d;
   logic [1:0]       nack_q, nack_d;

   logic [1:0]  live;
   logic [1:0]  tmask;
   logic        tp_live;
   logic [1:0]  tp_row;
   logic [1:0]  tp_col;
   logic [3:0]  idx;
   logic [15:0] occ;
   logic        legal;

   // A player's req is blind while its own response pulse is out.
   assign live[0] = io.p0_req & ~ack_q[0] & ~nack_q[0];
   assign live[1] = io.p1_req & ~ack_q[1] & ~nack_q[1];

   assign tmask   = turn_q ? 2'b10 : 2'b01;
   assign tp_live = |(live & tmask);
   assign tp_row  = turn_q ? io.p1_row : io.p0_row;
   assign tp_col  = turn_q ? io.p1_col : io.p0_col;
   assign idx     = {2'b00, tp_row} * 4'd3 + {2'b00, tp_col};
   assign occ     = {7'd0, io.board_valid};
   assign legal   = (tp_row != 2'd3) && (tp_col != 2'd3) && !occ[idx];

   always_comb begin
      state_d   = state_q;
      turn_d    = turn_q;
      result_d  = result_q;
      forfeit_d = forfeit_q;
      cnt_d     = cnt_q;
      row_d     = row_q;
      col_d     = col_q;
      set_d     = 1'b0;
      ack_d     = 2'b00;
      nack_d    = 2'b00;
      if (io.new_game) begin
         state_d   = S_CLEAR;
         turn_d    = 1'b0;
         result_d  = 2'b00;
         forfeit_d = 1'b0;
         cnt_d     = '0;
      end else begin
         unique case (state_q)
            S_CLEAR: begin
               turn_d    = 1'b0;
               result_d  = 2'b00;
               forfeit_d = 1'b0;
               cnt_d     = '0;
               state_d   = S_WAIT;
            end
            S_WAIT: begin
               cnt_d  = cnt_q + 1'b1;
               nack_d = live & ~tmask;
               if (tp_live && legal) begin
                  ack_d   = tmask;
                  set_d   = 1'b1;
                  row_d   = tp_row;
                  col_d   = tp_col;
                  state_d = S_ISSUE;
               end else begin
                  nack_d = live;
                  if (cnt_q == LAST) begin
                     forfeit_d = 1'b1;
                     result_d  = turn_q ? 2'b01 : 2'b10;
                     state_d   = S_DONE;
                  end
               end
            end
            S_ISSUE: state_d = S_SETTLE;
            S_SETTLE: begin
               if (io.board_game_state != 2'b00) begin
                  result_d = io.board_game_state;
                  state_d  = S_DONE;
               end else begin
                  turn_d  = ~turn_q;
                  cnt_d   = '0;
                  state_d = S_WAIT;
               end
            end
            S_DONE: nack_d = live;
            default: state_d = S_CLEAR;
         endcase
      end
      clr_d  = (state_d == S_CLEAR);
      busy_d = (state_d != S_WAIT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_CLEAR;
         turn_q    <= 1'b0;
         result_q  <= 2'b00;
         forfeit_q <= 1'b0;
         cnt_q     <= '0;
         set_q     <= 1'b0;
         clr_q     <= 1'b1;
         busy_q    <= 1'b1;
         row_q     <= 2'd0;
         col_q     <= 2'd0;
         ack_q     <= 2'b00;
         nack_q    <= 2'b00;
      end else begin
         state_q   <= state_d;
         turn_q    <= turn_d;
         result_q  <= result_d;
         forfeit_q <= forfeit_d;
         cnt_q     <= cnt_d;
         set_q     <= set_d;
         clr_q     <= clr_d;
         busy_q    <= busy_d;
         row_q     <= row_d;
         col_q     <= col_d;
         ack_q     <= ack_d;
         nack_q    <= nack_d;
      end
   end

   assign io.p0_ack      = ack_q[0];
   assign io.p1_ack      = ack_q[1];
   assign io.p0_nack     = nack_q[0];
   assign io.p1_nack     = nack_q[1];
   assign io.board_set   = set_q;
   assign io.board_reset = clr_q;
   assign io.board_row   = row_q;
   assign io.board_col   = col_q;
   assign io.turn        = turn_q;
   assign io.busy        = busy_q;
   assign io.result      = result_q;
   assign io.forfeit     = forfeit_q;

endmodule

// File: tb/tb_ttt_move_ctrl.sv
// Bench for ttt_move_ctrl: emulated board plus a move-level game model
// driven by directed scenarios and randomized games.
module tb_ttt_move_ctrl;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_pass;
   int   nset;

   ttt_move_ctrl_if bus ();

   ttt_move_ctrl #(
      .TIMEOUT_CYCLES(8),
      .CNT_W(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .io(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] eval(input int b[9]);
      int ln[8][3];
      int full;
      ln = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
             '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
      for (int i = 0; i < 8; i++)
         if (b[ln[i][0]] != 0 && b[ln[i][0]] == b[ln[i][1]]
             && b[ln[i][1]] == b[ln[i][2]])
            return (b[ln[i][0]] == 1) ? 2'b01 : 2'b10;
      full = 1;
      for (int i = 0; i < 9; i++) if (b[i] == 0) full = 0;
      return full ? 2'b11 : 2'b00;
   endfunction

   // board emulation: alternating marks, combinational game state
   int   bcell[9];
   logic bmover;

   always @(posedge clk) begin
      if (bus.board_set) nset <= nset + 1;
      if (bus.board_reset) begin
         for (int i = 0; i < 9; i++) bcell[i] <= 0;
         bmover <= 1'b0;
      end else if (bus.board_set) begin
         bcell[int'(bus.board_row) * 3 + int'(bus.board_col)] <= bmover ? 2 : 1;
         bmover <= ~bmover;
      end
   end

   always_comb begin
      for (int i = 0; i < 9; i++) bus.board_valid[i] = (bcell[i] != 0);
      bus.board_game_state = eval(bcell);
   end

   // reference game model
   int       mb[9];
   bit       mturn;
   logic [1:0] mres;

   task automatic model_clear();
      for (int i = 0; i < 9; i++) mb[i] = 0;
      mturn = 0;
      mres  = 2'b00;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic bit would_accept(int p, int r, int c);
      return (mres == 2'b00) && (p == int'(mturn)) && r <= 2 && c <= 2
             && mb[r * 3 + c] == 0;
   endfunction

   task automatic do_move(input int p, input int r, input int c);
      logic       ea;
      logic [4:0] obs;
      logic [4:0] exp;
      logic [4:0] ox;
      logic [4:0] ex;
      ea = would_accept(p, r, c);
      if (p == 0) begin
         bus.p0_req = 1; bus.p0_row = 2'(r); bus.p0_col = 2'(c);
      end else begin
         bus.p1_req = 1; bus.p1_row = 2'(r); bus.p1_col = 2'(c);
      end
      tick();
      obs = {bus.p0_ack, bus.p0_nack, bus.p1_ack, bus.p1_nack, bus.board_set};
      exp = (p == 0) ? {ea, !ea, 2'b00, ea} : {2'b00, ea, !ea, ea};
      n_chk++;
      if (obs !== exp)
         $display("FAIL resp p%0d (%0d,%0d): got %b want %b", p, r, c, obs, exp);
      else n_pass++;
      if (ea) begin
         n_chk++;
         if ({bus.board_row, bus.board_col} !== {2'(r), 2'(c)})
            $display("FAIL cell: got %0d,%0d want %0d,%0d",
                     bus.board_row, bus.board_col, r, c);
         else n_pass++;
      end
      bus.p0_req = 0;
      bus.p1_req = 0;
      tick();
      if (ea) begin
         n_chk++;
         if ({bus.board_set, bus.busy} !== 2'b01)
            $display("FAIL settle: set/busy got %b%b want 01",
                     bus.board_set, bus.busy);
         else n_pass++;
         mb[r * 3 + c] = p + 1;
         mres = eval(mb);
         if (mres == 2'b00) mturn = ~mturn;
         tick();
         ox = {bus.turn, bus.result, bus.busy, bus.forfeit};
         ex = {mturn, mres, mres != 2'b00, 1'b0};
         n_chk++;
         if (ox !== ex)
            $display("FAIL after_move: turn/res/busy/ff got %b want %b", ox, ex);
         else n_pass++;
      end else begin
         ox = {bus.p0_ack, bus.p0_nack, bus.p1_ack, bus.p1_nack, bus.board_set};
         n_chk++;
         if (ox !== 5'b0 || bus.turn !== mturn)
            $display("FAIL holdoff: pulses %b turn %b want 00000 %b",
                     ox, bus.turn, mturn);
         else n_pass++;
      end
   endtask

   task automatic start_game();
      bus.new_game = 1;
      tick();
      n_chk++;
      if ({bus.board_reset, bus.result, bus.turn, bus.busy, bus.forfeit} !== 6'b100010)
         $display("FAIL new_game clear: rst/res/turn/busy/ff got %b%b%b%b%b want 100010",
                  bus.board_reset, bus.result, bus.turn, bus.busy, bus.forfeit);
      else n_pass++;
      bus.new_game = 0;
      tick();
      n_chk++;
      if ({bus.board_reset, bus.busy} !== 2'b00)
         $display("FAIL new_game wait: rst/busy got %b%b want 00",
                  bus.board_reset, bus.busy);
      else n_pass++;
      model_clear();
   endtask

   task automatic test_reset();
      logic [14:0] o;
      reset = 1;
      repeat (3) tick();
      o = {bus.board_reset, bus.board_set, bus.board_row, bus.board_col,
           bus.p0_ack, bus.p0_nack, bus.p1_ack, bus.p1_nack,
           bus.turn, bus.result, bus.forfeit, bus.busy};
      n_chk++;
      if (o !== 15'b1_0_00_00_0000_0_00_0_1)
         $display("FAIL reset_vals: got %b want 100000000000001", o);
      else n_pass++;
      reset = 0;
      tick();
      n_chk++;
      if ({bus.busy, bus.turn, bus.board_reset} !== 3'b000)
         $display("FAIL post_reset: busy/turn/rst got %b%b%b want 000",
                  bus.busy, bus.turn, bus.board_reset);
      else n_pass++;
      model_clear();
   endtask

   task automatic test_first_and_illegal();
      do_move(0, 1, 1);
      do_move(1, 1, 1);
      do_move(1, 3, 0);
      do_move(0, 0, 0);
      do_move(1, 2, 2);
   endtask

   task automatic test_simultaneous();
      int n0;
      logic [4:0] o;
      start_game();
      n0 = nset;
      bus.p0_req = 1; bus.p0_row = 2; bus.p0_col = 2;
      bus.p1_req = 1; bus.p1_row = 0; bus.p1_col = 0;
      tick();
      o = {bus.p0_ack, bus.p0_nack, bus.p1_ack, bus.p1_nack, bus.board_set};
      n_chk++;
      if (o !== 5'b10011) $display("FAIL simul resp: got %b want 10011", o);
      else n_pass++;
      bus.p0_req = 0;
      bus.p1_req = 0;
      tick();
      tick();
      n_chk++;
      if (nset - n0 != 1 || bus.turn !== 1'b1)
         $display("FAIL simul writes: got %0d turn %b want 1 turn 1",
                  nset - n0, bus.turn);
      else n_pass++;
      mb[8] = 1;
      mturn = 1;
   endtask

   task automatic test_win();
      start_game();
      do_move(0, 0, 0);
      do_move(1, 1, 0);
      do_move(0, 0, 1);
      do_move(1, 1, 1);
      do_move(0, 0, 2);
      n_chk++;
      if (bus.result !== 2'b01) $display("FAIL win: got %b want 01", bus.result);
      else n_pass++;
      do_move(1, 2, 2);
      start_game();
   endtask

   task automatic test_timeout();
      logic [1:0] er;
      start_game();
      do_move(0, 1, 1);
      er = mturn ? 2'b01 : 2'b10;
      repeat (7) tick();
      n_chk++;
      if ({bus.forfeit, bus.busy} !== 2'b00)
         $display("FAIL pre_timeout: ff/busy got %b%b want 00", bus.forfeit, bus.busy);
      else n_pass++;
      tick();
      n_chk++;
      if ({bus.forfeit, bus.result, bus.busy} !== {1'b1, er, 1'b1})
         $display("FAIL timeout: ff/res/busy got %b%b%b want 1%b1",
                  bus.forfeit, bus.result, bus.busy, er);
      else n_pass++;
      start_game();
      do_move(0, 1, 1);
      repeat (7) tick();
      bus.p1_req = 1; bus.p1_row = 0; bus.p1_col = 0;
      tick();
      n_chk++;
      if ({bus.p1_ack, bus.board_set, bus.forfeit} !== 3'b110)
         $display("FAIL last_cycle_move: ack/set/ff got %b%b%b want 110",
                  bus.p1_ack, bus.board_set, bus.forfeit);
      else n_pass++;
      bus.p1_req = 0;
      tick();
      tick();
      n_chk++;
      if ({bus.turn, bus.result, bus.forfeit} !== 4'b0000)
         $display("FAIL after_last: turn/res/ff got %b%b%b want 0000",
                  bus.turn, bus.result, bus.forfeit);
      else n_pass++;
   endtask

   task automatic test_reset_in_settle();
      logic [7:0] o;
      start_game();
      do_move(0, 0, 0);
      do_move(1, 1, 0);
      do_move(0, 0, 1);
      do_move(1, 1, 1);
      bus.p0_req = 1; bus.p0_row = 0; bus.p0_col = 2;
      tick();
      bus.p0_req = 0;
      tick();
      reset = 1;
      tick();
      o = {bus.board_reset, bus.result, bus.turn,
           bus.p0_ack, bus.p0_nack, bus.p1_ack, bus.p1_nack};
      n_chk++;
      if (o !== 8'b1000_0000)
         $display("FAIL reset_settle: got %b want 10000000", o);
      else n_pass++;
      reset = 0;
      tick();
      tick();
      model_clear();
      n_chk++;
      if ({bus.busy, bus.result} !== 3'b000)
         $display("FAIL reset_settle recover: busy/res got %b%b want 000",
                  bus.busy, bus.result);
      else n_pass++;
   endtask

   task automatic test_random_games();
      int p, r, c, illeg, tries, k;
      for (int g = 0; g < 20; g++) begin
         start_game();
         illeg = 0;
         tries = 0;
         while (mres == 2'b00 && tries < 40) begin
            tries++;
            if (illeg >= 3) begin
               p = int'(mturn);
               k = $urandom_range(0, 8);
               while (mb[k] != 0) k = (k + 1) % 9;
               r = k / 3;
               c = k % 3;
            end else begin
               p = ($urandom_range(0, 4) == 0) ? int'(!mturn) : int'(mturn);
               r = $urandom_range(0, 3);
               c = $urandom_range(0, 3);
            end
            if (would_accept(p, r, c)) illeg = 0;
            else illeg++;
            do_move(p, r, c);
         end
         do_move($urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, 2));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clk = 0;
      reset = 1;
      n_chk = 0;
      n_pass = 0;
      nset = 0;
      bus.new_game = 0;
      bus.p0_req = 0; bus.p0_row = 0; bus.p0_col = 0;
      bus.p1_req = 0; bus.p1_row = 0; bus.p1_col = 0;
      model_clear();
      test_reset();
      test_first_and_illegal();
      test_simultaneous();
      test_win();
      test_timeout();
      test_reset_in_settle();
      test_random_games();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
